// File: rtl/sync_fifo_axis.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides, fill level and threshold flags.
// Optional synchronous flush is compiled in only when SYNC_FIFO_FLUSH_EN is defined.
module sync_fifo_axis #(
   parameter int DEPTH         = 16,
   parameter int WIDTH         = 32,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                         aclk,
   input  logic                         resetn,
   input  logic [WIDTH-1:0]             s_data_i,
   input  logic                         s_valid_i,
   output logic                         s_ready_o,
   output logic [WIDTH-1:0]             m_data_o,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   input  logic                         flush_i,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         almost_full_o,
   output logic                         almost_empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW-1:0]    rd_nxt_idx;
   logic             push;
   logic             pop;
   logic [LW-1:0]    level_nxt;

`ifndef SYNC_FIFO_FLUSH_EN
   logic unused_flush;
   assign unused_flush = flush_i;
`endif

   // Every stored word, including the one shown on m_data_o, stays in mem until popped.
   assign level_o    = LW'(wr_ptr - rd_ptr);
   assign rd_nxt_idx = rd_ptr[AW-1:0] + AW'(1);

   always_comb begin
      push      = s_valid_i && s_ready_o;
      pop       = m_valid_o && m_ready_i;
      level_nxt = level_o;
      if (push && !pop)
         level_nxt = level_o + LW'(1);
      else if (pop && !push)
         level_nxt = level_o - LW'(1);
   end

   always_ff @(posedge aclk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= s_data_i;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         m_data_o       <= '0;
         m_valid_o      <= 1'b0;
         s_ready_o      <= 1'b0;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
      end
`ifdef SYNC_FIFO_FLUSH_EN
      else if (flush_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         m_valid_o      <= 1'b0;
         s_ready_o      <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
      end
`endif
      else begin
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         m_valid_o      <= (level_nxt != '0);
         s_ready_o      <= (level_nxt < DEPTH_L);
         almost_full_o  <= (level_nxt >= AF_L);
         almost_empty_o <= (level_nxt <= AE_L);
         // Incoming word becomes head when the FIFO is, or is about to become, empty.
         if (push && ((level_o == '0) || (pop && (level_o == LW'(1)))))
            m_data_o <= s_data_i;
         else if (pop && (level_o > LW'(1)))
            m_data_o <= mem[rd_nxt_idx];
      end
   end

endmodule

// File: tb/tb_sync_fifo_axis.sv
// Scoreboard bench for sync_fifo_axis: directed phases plus a random handshake phase.
module tb_sync_fifo_axis;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;

   logic             aclk = 1'b0;
   logic             resetn;
   logic [WIDTH-1:0] s_data_i;
   logic             s_valid_i;
   logic             s_ready_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_valid_o;
   logic             m_ready_i;
   logic             flush_i;
   logic [4:0]       level_o;
   logic             almost_full_o;
   logic             almost_empty_o;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_q [$];
   int               mlevel = 0;
   bit               armed = 1'b0;
   bit               edge_rst = 1'b1;

   sync_fifo_axis #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(14), .AEMPTY_THRESH(1)) dut (
      .aclk(aclk), .resetn(resetn),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .flush_i(flush_i), .level_o(level_o),
      .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor samples just before each rising edge; inputs change on the falling edge.
   initial begin
      forever begin
         @(negedge aclk);
         #4;
         if (armed) begin
            chk("level", 64'(level_o), 64'(mlevel));
            chk("m_valid", 64'(m_valid_o), 64'(mlevel != 0));
            chk("s_ready", 64'(s_ready_o), edge_rst ? 64'd0 : 64'(mlevel < DEPTH));
            chk("almost_full", 64'(almost_full_o), 64'(mlevel >= 14));
            chk("almost_empty", 64'(almost_empty_o), 64'(mlevel <= 1));
            if (m_valid_o && exp_q.size() > 0)
               chk("head_data", 64'(m_data_o), 64'(exp_q[0]));
         end
         if (!resetn) begin
            mlevel = 0;
            exp_q.delete();
            edge_rst = 1'b1;
            armed = 1'b1;
         end else if (armed) begin
            edge_rst = 1'b0;
`ifdef SYNC_FIFO_FLUSH_EN
            if (flush_i) begin
               mlevel = 0;
               exp_q.delete();
            end else
`endif
            begin
               if (m_valid_o && m_ready_i) begin
                  if (exp_q.size() == 0) begin
                     chk("pop_nonempty", 64'd0, 64'd1);
                  end else begin
                     chk("pop_data", 64'(m_data_o), 64'(exp_q.pop_front()));
                     mlevel--;
                  end
               end
               if (s_valid_i && s_ready_o) begin
                  exp_q.push_back(s_data_i);
                  mlevel++;
               end
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
      s_valid_i = v;
      s_data_i  = d;
      m_ready_i = r;
      @(negedge aclk);
   endtask

   initial begin
      resetn = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0; flush_i = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_s_ready", 64'(s_ready_o), 64'd0);
      chk("rst_m_data", 64'(m_data_o), 64'd0);
      chk("rst_aempty", 64'(almost_empty_o), 64'd1);
      resetn = 1'b1;
      @(negedge aclk);
      chk("post_rst_s_ready", 64'(s_ready_o), 64'd1);

      // Three pushes, no pops: FWFT head is the first word.
      cyc(1'b1, 32'h11, 1'b0);
      chk("fwft_valid", 64'(m_valid_o), 64'd1);
      chk("fwft_data", 64'(m_data_o), 64'h11);
      cyc(1'b1, 32'h22, 1'b0);
      cyc(1'b1, 32'h33, 1'b0);
      chk("three_level", 64'(level_o), 64'd3);
      chk("three_head", 64'(m_data_o), 64'h11);
      chk("three_aempty", 64'(almost_empty_o), 64'd0);

      // Fill to DEPTH; almost_full asserts from level 14.
      for (int i = 3; i < 14; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
      chk("lvl14_afull", 64'(almost_full_o), 64'd1);
      cyc(1'b1, 32'h10E, 1'b0);
      cyc(1'b1, 32'h10F, 1'b0);
      chk("full_level", 64'(level_o), 64'd16);
      chk("full_s_ready", 64'(s_ready_o), 64'd0);
      cyc(1'b1, 32'hDEAD, 1'b0);
      chk("17th_refused", 64'(level_o), 64'd16);

      // Full: simultaneous valid/ready pops only.
      cyc(1'b1, 32'hBEEF, 1'b1);
      chk("full_pop_level", 64'(level_o), 64'd15);
      chk("full_pop_ready", 64'(s_ready_o), 64'd1);

      repeat (20) cyc(1'b0, '0, 1'b1);
      chk("drained", 64'(level_o), 64'd0);

      // Streaming through the wrap with level held at 1.
      for (int i = 0; i < 100; i++) begin
         cyc(1'b1, 32'h1000 + 32'(i), 1'b1);
         if (i > 0 && level_o != 5'd1) chk("stream_level", 64'(level_o), 64'd1);
      end
      chk("stream_level_end", 64'(level_o), 64'd1);
      chk("stream_head_end", 64'(m_data_o), 64'h1063);
      repeat (2) cyc(1'b0, '0, 1'b1);

      // Random handshakes.
      for (int i = 0; i < 2000; i++)
         cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

      // Mid-operation reset discards contents.
      cyc(1'b1, 32'h77, 1'b0);
      resetn = 1'b0;
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("midrst_level", 64'(level_o), 64'd0);
      resetn = 1'b1;
      cyc(1'b0, '0, 1'b0);

      // Flush at level 5 while pushing 0xAA.
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h50 + 32'(i), 1'b0);
      chk("pre_flush_level", 64'(level_o), 64'd5);
      flush_i = 1'b1;
      cyc(1'b1, 32'hAA, 1'b0);
      flush_i = 1'b0;
`ifdef SYNC_FIFO_FLUSH_EN
      chk("flush_level", 64'(level_o), 64'd0);
      chk("flush_valid", 64'(m_valid_o), 64'd0);
      chk("flush_s_ready", 64'(s_ready_o), 64'd1);
`else
      chk("noflush_level", 64'(level_o), 64'd6);
`endif
      repeat (10) cyc(1'b0, '0, 1'b1);
      chk("final_level", 64'(level_o), 64'd0);
      chk("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
